// File: rtl/seven_seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver_pkg
// Purpose  : Shared definitions for seven-segment display blocks. It holds the
//            segment bus width and the hex-to-segment table. Patterns are
//            active-high (1 = lit). Bit order is {a,b,c,d,e,f,g}, with seg[6]=a
//            and seg[0]=g.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_scan_driver_pkg;

  localparam int SEG_W = 7;

  // Active-high lit pattern for one hex nibble, bit order a..g (MSB = a).
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] hex);
    logic [SEG_W-1:0] pat;
    case (hex)
      4'h0:    pat = 7'b1111110;
      4'h1:    pat = 7'b0110000;
      4'h2:    pat = 7'b1101101;
      4'h3:    pat = 7'b1111001;
      4'h4:    pat = 7'b0110011;
      4'h5:    pat = 7'b1011011;
      4'h6:    pat = 7'b1011111;
      4'h7:    pat = 7'b1110000;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1111011;
      4'hA:    pat = 7'b1110111;
      4'hB:    pat = 7'b0011111;
      4'hC:    pat = 7'b1001110;
      4'hD:    pat = 7'b0111101;
      4'hE:    pat = 7'b1001111;
      default: pat = 7'b1000111;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver_if
// Purpose  : Bundles the image-load side and the display pin side of the scan
//            driver.
//            Image-load signals:
//              load                capture strobe
//              data_in[4*DIGITS]   hex nibbles, digit 0 is rightmost
//              dp_in / blank_in / blink_in [DIGITS]  per-digit attributes
//            Display pin signals:
//              seg[7]              {a..g} cathodes
//              dp                  decimal point
//              an[DIGITS]          digit enables
//              frame_tick          image commit pulse
//            Modports:
//              master              user logic (drives the image inputs)
//              slave               driver (drives the display pins)
// Revision : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  import seven_seg_scan_driver_pkg::*;

  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [DIGITS-1:0]     blink_in;
  logic [SEG_W-1:0]      seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (
    output load, data_in, dp_in, blank_in, blink_in,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  load, data_in, dp_in, blank_in, blink_in,
    output seg, dp, an, frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_driver_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver_hex_decode
// Purpose  : Combinational hex nibble to active-high seven-segment pattern.
// Ports    : hex [3:0] in  - nibble to display
//            seg [6:0] out - lit pattern {a..g}, 1 = lit
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver_hex_decode
  import seven_seg_scan_driver_pkg::*;
(
  input  wire  [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = hex_to_seg(hex);
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver
// Purpose  : Time-multiplexed N-digit hex seven-segment scan driver.
//            - Double-buffered digit image, committed at the frame boundary.
//            - Per-digit blank, blink and decimal point.
//            - Anti-ghosting guard at the start of each slot.
//            - Registered pin outputs.
// Ports    : clk  in - system clock
//            rst  in - asynchronous active-high reset
//            bus  slave modport:
//                   load, data_in, dp_in, blank_in, blink_in  in
//                   seg, dp, an, frame_tick                   out
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int GUARD          = 16,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input wire                    clk,
  input wire                    rst,
  seven_seg_scan_driver_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  localparam logic [DIGITS-1:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [SEG_W-1:0]  SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic              DP_IDLE  = (SEG_ACTIVE_LOW != 0);

  // Scan and blink timing state
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [FRM_W-1:0]           frm_q, frm_d;
  logic                       phase_q, phase_d;   // 1 = blink-on phase

  // Pending and displayed images
  logic [DIGITS-1:0][3:0]     pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0]          pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]          pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic [DIGITS-1:0]          pend_blink_q, pend_blink_d, disp_blink_q, disp_blink_d;

  // Registered pins
  logic [DIGITS-1:0]          an_q, an_d;
  logic [SEG_W-1:0]           seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic                       frame_tick_q, frame_tick_d;

  logic                       guard_ok;
  logic [SEG_W-1:0]           dec_seg;

  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = (cnt_q >= CNT_W'(GUARD));
    end
  endgenerate

  seven_seg_scan_driver_hex_decode u_hex_decode (
    .hex (disp_data_q[idx_q]),
    .seg (dec_seg)
  );

  always_comb begin
    logic                   last_cnt;
    logic                   boundary;
    logic                   digit_on;
    logic [DIGITS-1:0]      an_onehot;
    logic [SEG_W-1:0]       seg_raw;
    logic                   dp_raw;

    last_cnt = (cnt_q == CNT_LAST);
    boundary = last_cnt && (idx_q == IDX_LAST);

    cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (last_cnt) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    frm_d   = frm_q;
    phase_d = phase_q;
    if (boundary) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    // The display takes the post-load pending value. A load on the boundary
    // cycle therefore lands in the very next frame.
    pend_data_d  = bus.load ? bus.data_in  : pend_data_q;
    pend_dp_d    = bus.load ? bus.dp_in    : pend_dp_q;
    pend_blank_d = bus.load ? bus.blank_in : pend_blank_q;
    pend_blink_d = bus.load ? bus.blink_in : pend_blink_q;

    disp_data_d  = boundary ? pend_data_d  : disp_data_q;
    disp_dp_d    = boundary ? pend_dp_d    : disp_dp_q;
    disp_blank_d = boundary ? pend_blank_d : disp_blank_q;
    disp_blink_d = boundary ? pend_blink_d : disp_blink_q;

    // The guard keeps all anodes dark across the idx change. At most one
    // anode is ever enabled.
    digit_on = guard_ok && !disp_blank_q[idx_q] &&
               !(!phase_q && disp_blink_q[idx_q]);

    an_onehot = '0;
    if (digit_on) begin
      an_onehot[idx_q] = 1'b1;
    end
    seg_raw = digit_on ? dec_seg : '0;
    dp_raw  = digit_on && disp_dp_q[idx_q];

    an_d         = (AN_ACTIVE_LOW != 0)  ? ~an_onehot : an_onehot;
    seg_d        = (SEG_ACTIVE_LOW != 0) ? ~seg_raw   : seg_raw;
    dp_d         = (SEG_ACTIVE_LOW != 0) ? ~dp_raw    : dp_raw;
    frame_tick_d = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b1;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      pend_blink_q <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      disp_blink_q <= '0;
      an_q         <= AN_IDLE;
      seg_q        <= SEG_IDLE;
      dp_q         <= DP_IDLE;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_blink_q <= pend_blink_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      disp_blink_q <= disp_blink_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
`default_nettype wire
